// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } muldiv_op_t;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PREP = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      PREP = ST_PREP,
      RUN  = ST_RUN,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input muldiv_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration on {acc, q}.
import muldiv_pkg::*;

module muldiv_step #(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   acc_nx,
   output logic [WIDTH-1:0] q_nx
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum    = acc + {1'b0, m};
      sh     = {acc[WIDTH-1:0], q[WIDTH-1]};
      diff   = {1'b0, sh} - {2'b00, m};
      acc_nx = acc;
      q_nx   = q;
      if (is_div) begin
         // Borrow out of the trial subtraction means restore the shifted value.
         if (diff[WIDTH+1]) begin
            acc_nx = sh;
            q_nx   = {q[WIDTH-2:0], 1'b0};
         end else begin
            acc_nx = diff[WIDTH:0];
            q_nx   = {q[WIDTH-2:0], 1'b1};
         end
      end else begin
         if (!q[0]) sum = acc;
         acc_nx = {1'b0, sum[WIDTH:1]};
         q_nx   = {sum[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional divide-by-zero exception path: define MULDIV_DIVZERO_EXC_EN.
import muldiv_pkg::*;

module muldiv_ctrl #(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Abort,
   input  logic             WrHi,
   input  logic             WrLo,
   input  logic [WIDTH-1:0] WrData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
`ifdef MULDIV_DIVZERO_EXC_EN
   ,
   output logic             DivZero
`endif
);

   muldiv_state_t      state;
   muldiv_op_t         op;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   m;
   logic               neg_q;
   logic               neg_r;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     acc_nx;
   logic [WIDTH-1:0]   q_nx;
   logic               sgn_in;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo_neg;
   logic [WIDTH-1:0]   rem_neg;
`ifdef MULDIV_DIVZERO_EXC_EN
   logic               dz;
`endif

   always_comb begin
      sgn_in   = ~Op[0];
      a_mag    = (sgn_in && A[WIDTH-1]) ? -A : A;
      b_mag    = (sgn_in && B[WIDTH-1]) ? -B : B;
      prod_neg = -{acc[WIDTH-1:0], q};
      quo_neg  = -q;
      rem_neg  = -acc[WIDTH-1:0];
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (op_is_div(op)),
      .acc    (acc),
      .q      (q),
      .m      (m),
      .acc_nx (acc_nx),
      .q_nx   (q_nx)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         op    <= MD_MULT;
         acc   <= '0;
         q     <= '0;
         m     <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
         Hi    <= '0;
         Lo    <= '0;
`ifdef MULDIV_DIVZERO_EXC_EN
         dz    <= 1'b0;
`endif
      end else if (Abort && state != IDLE) begin
         state <= IDLE;
`ifdef MULDIV_DIVZERO_EXC_EN
         dz    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (WrHi) Hi <= WrData;
               if (WrLo) Lo <= WrData;
               if (Start && !Abort) begin
                  state <= PREP;
                  op    <= muldiv_op_t'(Op);
                  q     <= a_mag;
                  m     <= b_mag;
                  neg_q <= sgn_in & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_r <= sgn_in & A[WIDTH-1];
               end
            end
            PREP: begin
               acc   <= '0;
               cnt   <= '0;
               state <= RUN;
`ifdef MULDIV_DIVZERO_EXC_EN
               if (op_is_div(op) && m == '0) begin
                  dz    <= 1'b1;
                  state <= DONE;
               end
`endif
            end
            RUN: begin
               acc <= acc_nx;
               q   <= q_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               // Both results end up as Hi=acc, Lo=q, so DONE needs no op decode.
               if (op_is_signed(op)) begin
                  if (op_is_div(op)) begin
                     if (neg_q) q   <= quo_neg;
                     if (neg_r) acc <= {1'b0, rem_neg};
                  end else if (neg_q) begin
                     acc <= {1'b0, prod_neg[2*WIDTH-1:WIDTH]};
                     q   <= prod_neg[WIDTH-1:0];
                  end
               end
               state <= DONE;
            end
            DONE: begin
`ifdef MULDIV_DIVZERO_EXC_EN
               if (!dz) begin
                  Hi <= acc[WIDTH-1:0];
                  Lo <= q;
               end
               dz <= 1'b0;
`else
               Hi <= acc[WIDTH-1:0];
               Lo <= q;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = (state != IDLE);
   assign Done = (state == DONE) && !Abort;
`ifdef MULDIV_DIVZERO_EXC_EN
   assign DivZero = (state == DONE) && dz && !Abort;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Abort;
   logic        WrHi;
   logic        WrLo;
   logic [31:0] WrData;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;
`ifdef MULDIV_DIVZERO_EXC_EN
   logic        DivZero;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Abort   (Abort),
      .WrHi    (WrHi),
      .WrLo    (WrLo),
      .WrData  (WrData),
      .Busy    (Busy),
      .Done    (Done),
      .Hi      (Hi),
      .Lo      (Lo)
`ifdef MULDIV_DIVZERO_EXC_EN
      ,
      .DivZero (DivZero)
`endif
   );

   initial forever #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Reference: MIPS HI/LO results from 64-bit arithmetic.
   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, qq, rr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      hi = '0;
      lo = '0;
      case (op)
         2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         2'b10: begin
            if (b == 0) begin
               lo = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
               hi = a;
            end else begin
               qq = sa / sb;
               rr = sa % sb;
               lo = qq[31:0];
               hi = rr[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] eh, el;
      int lat, n;
      logic dzc;
      ref_model(op, a, b, eh, el);
      lat = 35;
      dzc = 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
      if (op[1] && b == 0) begin
         lat = 2;
         dzc = 1'b1;
         eh  = m_hi;
         el  = m_lo;
      end
`endif
      Op = op; A = a; B = b; Start = 1'b1;
      step();
      Start = 1'b0;
      chk({tag, " busy"}, 32'(Busy), 32'd1);
      n = 1;
      while (Done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk({tag, " done cycle"}, 32'(n), 32'(lat));
`ifdef MULDIV_DIVZERO_EXC_EN
      chk({tag, " divzero"}, 32'(DivZero), 32'(dzc));
`else
      if (dzc) $display("note: unexpected divzero case");
`endif
      step();
      chk({tag, " hi"}, Hi, eh);
      chk({tag, " lo"}, Lo, el);
      chk({tag, " idle"}, 32'(Busy), 32'd0);
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      int dcount;
      int n;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      Reset_n = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
      Abort = 1'b0; WrHi = 1'b0; WrLo = 1'b0; WrData = '0;
      repeat (3) step();
      chk("reset busy", 32'(Busy), 32'd0);
      chk("reset done", 32'(Done), 32'd0);
      chk("reset hi", Hi, 32'd0);
      chk("reset lo", Lo, 32'd0);
      Reset_n = 1'b1;
      step();

      run_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD);
      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("divu 100/7", 2'b11, 32'd100, 32'd7);
      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu 5/0", 2'b11, 32'd5, 32'd0);
      run_op("div -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0);

      WrLo = 1'b1; WrData = 32'h1234;
      step();
      WrLo = 1'b0;
      chk("mtlo lo", Lo, 32'h1234);
      chk("mtlo hi", Hi, m_hi);
      m_lo = 32'h1234;
      WrHi = 1'b1; WrData = 32'hCAFE_0001;
      step();
      WrHi = 1'b0;
      chk("mthi hi", Hi, 32'hCAFE_0001);
      m_hi = 32'hCAFE_0001;

      // WrHi while busy ignored; Start while busy ignored; single Done.
      Op = 2'b11; A = 32'd100; B = 32'd7; Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (4) step();
      WrHi = 1'b1; WrData = 32'hDEAD_BEEF;
      step();
      WrHi = 1'b0;
      chk("mthi busy", Hi, m_hi);
      Op = 2'b01; A = 32'd9; B = 32'd9; Start = 1'b1;
      step();
      Start = 1'b0;
      dcount = 0;
      repeat (60) begin
         if (Done === 1'b1) dcount++;
         step();
      end
      chk("busy start done count", 32'(dcount), 32'd1);
      chk("busy start hi", Hi, 32'd2);
      chk("busy start lo", Lo, 32'd14);
      m_hi = 32'd2; m_lo = 32'd14;

      // Write in the Start cycle lands first, result overwrites later.
      Op = 2'b01; A = 32'd3; B = 32'd5; Start = 1'b1; WrLo = 1'b1; WrData = 32'h5555;
      step();
      Start = 1'b0; WrLo = 1'b0;
      chk("wr+start lo early", Lo, 32'h5555);
      n = 1;
      while (Done !== 1'b1 && n < 100) begin step(); n++; end
      chk("wr+start done cycle", 32'(n), 32'd35);
      step();
      chk("wr+start hi", Hi, 32'd0);
      chk("wr+start lo", Lo, 32'd15);
      m_hi = 32'd0; m_lo = 32'd15;

      for (int i = 0; i < 16; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 40);
            3:       rb = -($urandom_range(1, 40));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
      end

      // Abort in cycle 10 of a MULT.
      Op = 2'b00; A = $urandom; B = $urandom; Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (9) step();
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      chk("abort busy", 32'(Busy), 32'd0);
      chk("abort done", 32'(Done), 32'd0);
      dcount = 0;
      repeat (40) begin
         step();
         if (Done === 1'b1) dcount++;
      end
      chk("abort no done", 32'(dcount), 32'd0);
      chk("abort hi", Hi, m_hi);
      chk("abort lo", Lo, m_lo);

      // Abort during DONE suppresses Done and the Hi/Lo write.
      Op = 2'b11; A = 32'd1000; B = 32'd3; Start = 1'b1;
      step();
      Start = 1'b0;
      n = 1;
      while (Done !== 1'b1 && n < 100) begin step(); n++; end
      chk("abort-done cycle", 32'(n), 32'd35);
      Abort = 1'b1;
      #1;
      chk("abort-done done", 32'(Done), 32'd0);
      step();
      Abort = 1'b0;
      chk("abort-done busy", 32'(Busy), 32'd0);
      chk("abort-done hi", Hi, m_hi);
      chk("abort-done lo", Lo, m_lo);

      // Start and Abort together in IDLE: Start dropped.
      Start = 1'b1; Abort = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd2;
      step();
      Start = 1'b0; Abort = 1'b0;
      chk("start+abort busy", 32'(Busy), 32'd0);

      // Asynchronous reset in cycle 20 of a DIV.
      Op = 2'b10; A = $urandom; B = 32'd13; Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (19) step();
      Reset_n = 1'b0;
      #1;
      chk("midreset busy", 32'(Busy), 32'd0);
      chk("midreset done", 32'(Done), 32'd0);
      chk("midreset hi", Hi, 32'd0);
      chk("midreset lo", Lo, 32'd0);
      step();
      Reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
      step();
      run_op("post reset divu", 2'b11, 32'd77, 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
